spike_synapse_decoder: RTL

- Receiving end of the neuron spike interface: converts a 1-bit spike train into the 20-bit signed Q4.16 synaptic current that drives a downstream neuron's I input.
- Applies an axonal delay, a refractory filter, a weighted current injection with exponential decay and saturation.
- Decodes the train into inter-spike intervals (ISI) for rate monitoring.

---
 rtl/neuron_pkg.sv | 28 ++
 rtl/spike_delay_line.sv | 38 +++
 rtl/spike_synapse_decoder.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/neuron_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : neuron_pkg
//  Purpose  : Shared Q4.16 fixed-point definitions for the neuron datapath
//             and the spike synapse decoder.
//  Contents : DATA_W, FRAC_W, Q_MAX, Q_MIN, Q_ONE, sat21()
//  Revision : 1.0  initial release
// ============================================================================
package neuron_pkg;

    localparam int DATA_W = 20;
    localparam int FRAC_W = 16;

    localparam logic signed [DATA_W-1:0] Q_MAX = 20'sh7FFFF;
    localparam logic signed [DATA_W-1:0] Q_MIN = 20'sh80000;
    localparam logic signed [DATA_W-1:0] Q_ONE = 20'sh10000;

    // Clamp a 21-bit signed intermediate to the 20-bit Q4.16 range. The two
    // top bits differ only when the value left the representable range.
    function automatic logic signed [DATA_W-1:0] sat21(input logic signed [DATA_W:0] s);
        if (s[DATA_W] != s[DATA_W-1]) begin
            return s[DATA_W] ? Q_MIN : Q_MAX;
        end
        return s[DATA_W-1:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/spike_delay_line.sv
`default_nettype none
// ============================================================================
//  Module   : spike_delay_line
//  Purpose  : Enabled shift register implementing the axonal delay. A spike
//             sampled on an enabled edge emerges on o_spike exactly DEPTH
//             enabled edges later. o_pending flags any spike still in flight
//             (including the one currently presented on o_spike).
//  Ports    : clk, rst (sync, active-high), i_en, i_spike -> o_spike,
//             o_pending
//  Revision : 1.0  initial release
// ============================================================================
module spike_delay_line #(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    input  logic i_spike,
    output logic o_spike,
    output logic o_pending
);

    // Stage 0 captures the input; stage DEPTH is the registered output.
    logic [DEPTH:0] r_line;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_line <= '0;
        end else if (i_en) begin
            r_line <= {r_line[DEPTH-1:0], i_spike};
        end
    end

    assign o_spike   = r_line[DEPTH];
    assign o_pending = |r_line;

endmodule
`default_nettype wire

// File: rtl/spike_synapse_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : spike_synapse_decoder
//  Purpose  : Converts a 1-bit spike train into a Q4.16 synaptic current with
//             axonal delay, refractory filtering, exponential decay and
//             saturation, and measures inter-spike intervals of accepted
//             spikes.
//  Ports    : clk, reset (sync, active-high), en, spike_in, weight[19:0]
//             -> I_out[19:0], spike_d, isi[ISI_W-1:0], isi_valid, busy
//  Revision : 1.0  initial release
// ============================================================================
module spike_synapse_decoder
    import neuron_pkg::*;
#(
    parameter int DELAY     = 4,
    parameter int TAU_SHIFT = 3,
    parameter int REFRAC    = 2,
    parameter int ISI_W     = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     en,
    input  logic                     spike_in,
    input  logic signed [DATA_W-1:0] weight,
    output logic signed [DATA_W-1:0] I_out,
    output logic                     spike_d,
    output logic [ISI_W-1:0]         isi,
    output logic                     isi_valid,
    output logic                     busy
);

    localparam int c_RW = (REFRAC < 2) ? 1 : $clog2(REFRAC + 1);
    localparam logic [c_RW-1:0] c_REFRAC_LD = c_RW'(REFRAC);
    // Values strictly inside (-c_DB, c_DB) would stall under the shift decay.
    localparam logic signed [DATA_W-1:0] c_DB = DATA_W'(1 << TAU_SHIFT);

    localparam logic [0:0] c_ACT_IDLE   = 1'b0;
    localparam logic [0:0] c_ACT_ACTIVE = 1'b1;
    localparam logic [0:0] c_ISI_FIRST  = 1'b0;
    localparam logic [0:0] c_ISI_COUNT  = 1'b1;

    logic signed [DATA_W-1:0] r_i;
    logic [c_RW-1:0]          r_refrac;
    logic [0:0]               r_act_state;
    logic [0:0]               r_isi_state;
    logic [ISI_W-1:0]         r_cnt;
    logic [ISI_W-1:0]         r_isi;
    logic                     r_isi_valid;

    logic                     w_spike_d;
    logic                     w_pending;
    logic                     w_accept;
    logic                     w_dead;
    logic signed [DATA_W:0]   w_i_ext;
    logic signed [DATA_W:0]   w_decay;
    logic signed [DATA_W:0]   w_wadd;
    logic signed [DATA_W:0]   w_sum;
    logic [ISI_W-1:0]         w_cnt_inc;

    spike_delay_line #(
        .DEPTH (DELAY)
    ) u_delay (
        .clk       (clk),
        .rst       (reset),
        .i_en      (en),
        .i_spike   (spike_in),
        .o_spike   (w_spike_d),
        .o_pending (w_pending)
    );

    assign w_accept = w_spike_d && (r_refrac == '0);

    // 21-bit datapath: decay and injection cannot overflow before clamping.
    assign w_i_ext = {r_i[DATA_W-1], r_i};
    assign w_decay = w_i_ext >>> TAU_SHIFT;
    assign w_wadd  = w_accept ? {weight[DATA_W-1], weight} : '0;
    assign w_sum   = w_i_ext - w_decay + w_wadd;
    assign w_dead  = !w_accept && (r_i > -c_DB) && (r_i < c_DB);

    assign w_cnt_inc = (&r_cnt) ? r_cnt : r_cnt + 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_i         <= '0;
            r_refrac    <= '0;
            r_act_state <= c_ACT_IDLE;
            r_isi_state <= c_ISI_FIRST;
            r_cnt       <= '0;
            r_isi       <= '0;
            r_isi_valid <= 1'b0;
        end else begin
            r_isi_valid <= 1'b0;
            if (en) begin
                r_i <= w_dead ? '0 : sat21(w_sum);

                if (w_accept) begin
                    r_refrac <= c_REFRAC_LD;
                end else if (r_refrac != '0) begin
                    r_refrac <= r_refrac - 1'b1;
                end

                case (r_act_state)
                    c_ACT_IDLE: begin
                        if (w_pending || (r_i != '0)) begin
                            r_act_state <= c_ACT_ACTIVE;
                        end
                    end
                    default: begin
                        if (!w_pending && (r_i == '0) && !w_accept) begin
                            r_act_state <= c_ACT_IDLE;
                        end
                    end
                endcase

                case (r_isi_state)
                    c_ISI_FIRST: begin
                        if (w_accept) begin
                            r_cnt       <= '0;
                            r_isi_state <= c_ISI_COUNT;
                        end
                    end
                    default: begin
                        if (w_accept) begin
                            // Interval includes the accept cycle itself.
                            r_isi       <= w_cnt_inc;
                            r_isi_valid <= 1'b1;
                            r_cnt       <= '0;
                        end else begin
                            r_cnt <= w_cnt_inc;
                        end
                    end
                endcase
            end
        end
    end

    assign I_out     = r_i;
    assign spike_d   = w_spike_d;
    assign isi       = r_isi;
    assign isi_valid = r_isi_valid;
    assign busy      = (r_act_state == c_ACT_ACTIVE);

endmodule
`default_nettype wire
